// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, the control bundle carried into EX,
// writeback-source encoding and the immediate formatter.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC4 = 2'd1,
    WB_MEM = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    is_load;
    logic    op1_sel;  // 1: PC instead of rs1
    logic    op2_sel;  // 1: immediate instead of rs2
    logic    jump;
    logic    branch;
    wb_sel_e wb_sel;
    logic    illegal;
  } ctrl_t;

  // Formats the immediate by instruction type; types without one return 0.
  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'b0};
      OP_JAL:                   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_IMM: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 2R/1W register file with x0 hardwired to zero and write-first bypass, so a
// writeback landing this edge is visible to the instruction decoding now.
module id_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == '0)                       rs1_data_o = '0;
    else if (we_i && waddr_i == rs1_addr_i)     rs1_data_o = wdata_i;
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == '0)                       rs2_data_o = '0;
    else if (we_i && waddr_i == rs2_addr_i)     rs2_data_o = wdata_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32 decode stage with the ID/EX pipeline register: decode, regfile read,
// load-use stall, flush, and a valid/ready handoff to execute.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1_addr,
  output logic [REG_AW-1:0] ex_rs2_addr,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output ctrl_t             ex_ctrl,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    ctrl_t             ctrl;
  } idex_t;

  idex_t ex_q, ex_d;

  logic [6:0]        opc;
  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic [REG_AW-1:0] rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0]   rs1_rdata, rs2_rdata;
  logic [31:0]       imm32;
  ctrl_t             dec;
  logic              use1, use2, known, bad_idx;
  logic              hazard, pipe_en;

  assign opc   = if_inst[6:0];
  assign rd_f  = if_inst[11:7];
  assign rs1_f = if_inst[19:15];
  assign rs2_f = if_inst[24:20];
  assign rs1_a = rs1_f[REG_AW-1:0];
  assign rs2_a = rs2_f[REG_AW-1:0];
  assign rd_a  = rd_f[REG_AW-1:0];
  assign imm32 = imm_gen(if_inst);

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS), .REG_AW(REG_AW)) u_rf (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr_i (rs1_a),
    .rs2_addr_i (rs2_a),
    .rs1_data_o (rs1_rdata),
    .rs2_data_o (rs2_rdata),
    .we_i       (wb_we),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data)
  );

  always_comb begin
    dec   = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    known = 1'b1;
    case (opc)
      OP_LUI:    begin dec.reg_we = 1'b1; dec.op2_sel = 1'b1; dec.wb_sel = WB_IMM; end
      OP_AUIPC:  begin dec.reg_we = 1'b1; dec.op1_sel = 1'b1; dec.op2_sel = 1'b1; end
      OP_JAL:    begin dec.reg_we = 1'b1; dec.op1_sel = 1'b1; dec.op2_sel = 1'b1;
                       dec.jump = 1'b1; dec.wb_sel = WB_PC4; end
      OP_JALR:   begin dec.reg_we = 1'b1; dec.op2_sel = 1'b1; dec.jump = 1'b1;
                       dec.wb_sel = WB_PC4; use1 = 1'b1; end
      OP_BRANCH: begin dec.branch = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_LOAD:   begin dec.reg_we = 1'b1; dec.is_load = 1'b1; dec.op2_sel = 1'b1;
                       dec.wb_sel = WB_MEM; use1 = 1'b1; end
      OP_STORE:  begin dec.mem_we = 1'b1; dec.op2_sel = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_IMM:    begin dec.reg_we = 1'b1; dec.op2_sel = 1'b1; use1 = 1'b1; end
      OP_REG:    begin dec.reg_we = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      default:   known = 1'b0;
    endcase
    // Only fields the instruction actually uses can make it illegal (RV32E).
    bad_idx = (use1 && int'(rs1_f) >= NREGS) || (use2 && int'(rs2_f) >= NREGS) ||
              (dec.reg_we && int'(rd_f) >= NREGS);
    dec.illegal = !known || bad_idx;
    if (dec.illegal) begin
      dec.reg_we = 1'b0;
      dec.mem_we = 1'b0;
    end
  end

  assign hazard   = ex_q.valid && ex_q.ctrl.is_load && ex_q.rd != '0 &&
                    ((use1 && rs1_a == ex_q.rd) || (use2 && rs2_a == ex_q.rd));
  assign pipe_en  = !ex_q.valid || ex_ready;
  assign id_ready = pipe_en && !hazard && !reset;

  always_comb begin
    ex_d = ex_q;
    if (flush || (pipe_en && hazard)) begin
      ex_d.valid       = 1'b0;
      ex_d.ctrl.reg_we = 1'b0;
      ex_d.ctrl.mem_we = 1'b0;
    end else if (pipe_en) begin
      ex_d.valid       = if_valid;
      ex_d.pc          = if_pc;
      ex_d.pc4         = if_pc + XLEN'(4);
      ex_d.rs1_data    = rs1_rdata;
      ex_d.rs2_data    = rs2_rdata;
      ex_d.imm         = XLEN'($signed(imm32));
      ex_d.rs1_addr    = rs1_a;
      ex_d.rs2_addr    = rs2_a;
      ex_d.rd          = rd_a;
      ex_d.funct3      = if_inst[14:12];
      ex_d.funct7      = if_inst[31:25];
      ex_d.ctrl        = dec;
      // Empty slots must never write state downstream.
      ex_d.ctrl.reg_we = dec.reg_we && if_valid;
      ex_d.ctrl.mem_we = dec.mem_we && if_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_pc4      = ex_q.pc4;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_addr = ex_q.rs1_addr;
  assign ex_rs2_addr = ex_q.rs2_addr;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7   = ex_q.funct7;
  assign ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard plus directed
// hazard, bypass, stall, flush and reset sequences; an RV32E copy checks x20.
module tb_id_ex_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush, ex_ready, wb_we;
  logic [31:0] if_inst, if_pc, wb_data;
  logic [4:0]  wb_addr;

  logic        id_ready, ex_valid;
  logic [31:0] ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  ctrl_t       ex_ctrl;

  logic        id_ready16, ex_valid16;
  logic [31:0] ex_pc16, ex_pc416, ex_rs1_data16, ex_rs2_data16, ex_imm16;
  logic [3:0]  ex_rs1_addr16, ex_rs2_addr16, ex_rd16;
  logic [2:0]  ex_funct316;
  logic [6:0]  ex_funct716;
  ctrl_t       ex_ctrl16;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_ctrl(ex_ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  id_ex_stage #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready16), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid16),
    .ex_pc(ex_pc16), .ex_pc4(ex_pc416), .ex_rs1_data(ex_rs1_data16), .ex_rs2_data(ex_rs2_data16),
    .ex_imm(ex_imm16), .ex_rs1_addr(ex_rs1_addr16), .ex_rs2_addr(ex_rs2_addr16), .ex_rd(ex_rd16),
    .ex_funct3(ex_funct316), .ex_funct7(ex_funct716), .ex_ctrl(ex_ctrl16),
    .wb_we(wb_we), .wb_addr(wb_addr[3:0]), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_we, mem_we, is_load;
    logic [1:0]  wb_sel;
    logic        illegal;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rd;
    logic [5:0]  ctl;
  } exp_t;

  localparam int OW = 196;

  vec_t        vt [11];
  exp_t        sb [$];
  logic [31:0] rf [32] = '{default: 32'd0};
  logic [31:0] pc = 32'h0000_1000;
  int          errs = 0, checks = 0;
  logic        rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] outs();
    return {ex_valid, ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1_addr, ex_rs2_addr, ex_rd, ex_funct3, ex_funct7, ex_ctrl};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0)          return 32'd0;
    if (we && wa == idx)      return wd;
    return rf[idx];
  endfunction

  // One cycle: drive at negedge, predict, clock, then check the ID/EX contents.
  task automatic drive(input vec_t v, input logic vld, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, output logic r);
    exp_t e;
    logic acc, pe;
    logic [OW-1:0] snap;
    if_inst = v.inst; if_valid = vld; if_pc = pc;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    r    = id_ready;
    acc  = vld && id_ready && !flush;
    pe   = !ex_valid || ex_ready;
    snap = outs();
    if (acc) begin
      e.pc   = pc;
      e.imm  = v.imm;
      e.rs1d = rd_model(v.inst[19:15], we, wa, wd);
      e.rs2d = rd_model(v.inst[24:20], we, wa, wd);
      e.rd   = v.rd;
      e.ctl  = {v.reg_we, v.mem_we, v.is_load, v.wb_sel, v.illegal};
      sb.push_back(e);
    end
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    else if (we && wa != 5'd0) rf[wa] = wd;
    #1;
    if (reset) begin
      chk("reset_valid", 32'(ex_valid), 32'd0);
      chkw("reset_outs", outs(), '0);
    end else if (acc) begin
      e = sb.pop_front();
      chk("valid", 32'(ex_valid), 32'd1);
      chk("pc", ex_pc, e.pc);
      chk("pc4", ex_pc4, e.pc + 32'd4);
      chk("imm", ex_imm, e.imm);
      chk("rs1_data", ex_rs1_data, e.rs1d);
      chk("rs2_data", ex_rs2_data, e.rs2d);
      chk("rd", 32'(ex_rd), 32'(e.rd));
      chk("ctrl", 32'({ex_ctrl.reg_we, ex_ctrl.mem_we, ex_ctrl.is_load, ex_ctrl.wb_sel,
                       ex_ctrl.illegal}), 32'(e.ctl));
    end else if (flush || pe) begin
      chk("bubble_valid", 32'(ex_valid), 32'd0);
      chk("bubble_we", 32'({ex_ctrl.reg_we, ex_ctrl.mem_we}), 32'd0);
    end else begin
      chkw("stall_hold", outs(), snap);
    end
    if (acc) pc += 32'd4;
    @(negedge clk);
  endtask

  initial begin
    vec_t nop, v;
    nop = '0;
    // inst, imm, rd, reg_we, mem_we, is_load, wb_sel, illegal
    vt[0]  = '{32'h00500093, 32'h00000005, 5'd1,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // addi x1,x0,5
    vt[1]  = '{32'hFFF00313, 32'hFFFFFFFF, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // addi x6,x0,-1
    vt[2]  = '{32'h123453B7, 32'h12345000, 5'd7,  1'b1, 1'b0, 1'b0, 2'd3, 1'b0}; // lui
    vt[3]  = '{32'h008000EF, 32'h00000008, 5'd1,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0}; // jal x1,8
    vt[4]  = '{32'hFE60AE23, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0}; // sw x6,-4(x1)
    vt[5]  = '{32'hFE608CE3, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}; // beq -8
    vt[6]  = '{32'h0000007F, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1}; // bad opcode
    vt[7]  = '{32'h00001417, 32'h00001000, 5'd8,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // auipc
    vt[8]  = '{32'h0040A483, 32'h00000004, 5'd9,  1'b1, 1'b0, 1'b1, 2'd2, 1'b0}; // lw x9,4(x1)
    vt[9]  = '{32'h00608533, 32'h00000000, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // add x10,x1,x6
    vt[10] = '{32'h00208A33, 32'h00000000, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // add x20,x1,x2

    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive(vt[0], 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("reset_id_ready", 32'(rdy), 32'd0);
    drive(vt[0], 1'b1, 1'b1, 5'd1, 32'h77, rdy);
    reset = 1'b0;

    drive(nop, 1'b0, 1'b1, 5'd1, 32'h100, rdy);
    drive(nop, 1'b0, 1'b1, 5'd6, 32'h600, rdy);
    drive(nop, 1'b0, 1'b1, 5'd2, 32'h222, rdy);

    for (int i = 0; i < 11; i++) drive(vt[i], 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("rv32e_valid", 32'(ex_valid16), 32'd1);
    chk("rv32e_illegal", 32'(ex_ctrl16.illegal), 32'd1);
    chk("rv32e_reg_we", 32'(ex_ctrl16.reg_we), 32'd0);

    // load-use: exactly one bubble
    v = '{32'h0000A103, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    v = '{32'h001101B3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("loaduse_stall_ready", 32'(rdy), 32'd0);
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("loaduse_issue_ready", 32'(rdy), 32'd1);

    // write-first bypass and x0
    v = '{32'h000202B3, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    drive(v, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF, rdy);
    chk("bypass_rs1", ex_rs1_data, 32'hDEADBEEF);
    v.inst = 32'h000002B3;
    drive(v, 1'b1, 1'b1, 5'd0, 32'h12345678, rdy);
    chk("x0_bypass", ex_rs1_data, 32'd0);
    v.inst = 32'h000202B3;
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("x4_written", ex_rs1_data, 32'hDEADBEEF);

    // back-pressure for three cycles, then flush while still stalled
    v = '{32'h00700593, 32'h7, 5'd11, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    ex_ready = 1'b0;
    v = '{32'h00C00613, 32'hC, 5'd12, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
      chk("stall_id_ready", 32'(rdy), 32'd0);
    end
    flush = 1'b1;
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);

    // flush beats a load-use hazard
    v = '{32'h0000A683, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    v = '{32'h00068733, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    flush = 1'b1;
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    flush = 1'b0;
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);

    // flush keeps id_ready high but discards the incoming instruction
    flush = 1'b1;
    drive(vt[0], 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("flush_id_ready", 32'(rdy), 32'd1);
    flush = 1'b0;

    // reset mid-operation drops the entry and blocks the write
    drive(vt[0], 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    reset = 1'b1;
    drive(vt[1], 1'b1, 1'b1, 5'd3, 32'h55, rdy);
    reset = 1'b0;
    v = '{32'h000182B3, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    drive(v, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk("x3_after_reset", ex_rs1_data, 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
